// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stalls, flushes, operand forwarding,
// multi-cycle mult/div sequencing and saturating stall/flush statistics.
module hazard_ctrl #(
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             JumpD,
   input  logic             JumpRegD,
   input  logic             PCSrcD,
   input  logic             mdUseD,
   input  logic             mdStartE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             mdBusy,
   output logic             mdErr,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   localparam int unsigned MdCntW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
   localparam logic [MdCntW-1:0] MdCntLoad = MdCntW'(MD_LATENCY - 1);

   typedef enum logic {StIdle, StBusy} md_state_e;

   md_state_e         state_q, state_d;
   logic [MdCntW-1:0] cnt_q, cnt_d;
   logic              md_err_q, md_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic       lw_stall, br_stall, md_stall, stall;
   logic       br_rt_cmp, br_dep_e, br_dep_m;
   logic       md_busy_raw, flush_d_raw;
   logic       fwd_ad_raw, fwd_bd_raw;
   logic [1:0] fwd_ae_raw, fwd_be_raw;

   // Register $0 is hard-wired, so it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != 5'd0) && (dst == src);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wr_m,
                                          input logic [4:0] dst_m, input logic wr_w,
                                          input logic [4:0] dst_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && reg_match(dst_m, src)) begin
         sel = 2'b10;
      end else if (wr_w && reg_match(dst_w, src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Hazard detection
   always_comb begin
      lw_stall  = MemtoRegE & (reg_match(RtE, RsD) | reg_match(RtE, RtD));
      // jr only reads rs, so rt must not cause a spurious stall.
      br_rt_cmp = BranchD & ~JumpRegD;
      br_dep_e  = RegWriteE & (reg_match(WriteRegE, RsD) |
                               (br_rt_cmp & reg_match(WriteRegE, RtD)));
      br_dep_m  = MemtoRegM & (reg_match(WriteRegM, RsD) |
                               (br_rt_cmp & reg_match(WriteRegM, RtD)));
      br_stall  = (BranchD | JumpRegD) & (br_dep_e | br_dep_m);

      md_busy_raw = (state_q == StBusy) | mdStartE;
      md_stall    = mdUseD & md_busy_raw;

      stall       = lw_stall | br_stall | md_stall;
      flush_d_raw = (PCSrcD | JumpD | JumpRegD) & ~stall;
   end

   // Forwarding selects
   always_comb begin
      fwd_ad_raw = RegWriteM & reg_match(WriteRegM, RsD);
      fwd_bd_raw = RegWriteM & reg_match(WriteRegM, RtD);
      fwd_ae_raw = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      fwd_be_raw = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   end

   // Reset forces a bubble into both pipeline registers and silences everything else.
   always_comb begin
      StallF    = stall & ~reset;
      StallD    = stall & ~reset;
      FlushE    = stall | reset;
      FlushD    = flush_d_raw | reset;
      ForwardAD = fwd_ad_raw & ~reset;
      ForwardBD = fwd_bd_raw & ~reset;
      ForwardAE = reset ? 2'b00 : fwd_ae_raw;
      ForwardBE = reset ? 2'b00 : fwd_be_raw;
      mdBusy    = md_busy_raw & ~reset;
      mdErr     = md_err_q;
   end

   // Mult/div sequencer next state
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_err_d = md_err_q;
      unique case (state_q)
         StIdle: begin
            if (mdStartE) begin
               state_d = StBusy;
               cnt_d   = MdCntLoad;
            end
         end
         StBusy: begin
            // A start while busy is a protocol error; the countdown is left untouched.
            if (mdStartE) begin
               md_err_d = 1'b1;
            end
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - MdCntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         md_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_err_q <= md_err_d;
      end
   end

   // Saturating statistics
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_d_raw && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stallCycles = stall_cnt_q;
   assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: cycle-level model compared every cycle, plus
// directed vectors with literal expectations.
module tb_hazard_ctrl;

   localparam int unsigned Lat    = 4;
   localparam int unsigned CntW   = 4;
   localparam int          SatMax = (1 << CntW) - 1;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [4:0]      RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic            RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic            BranchD, JumpD, JumpRegD, PCSrcD, mdUseD, mdStartE;
   logic            StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
   logic [1:0]      ForwardAE, ForwardBE;
   logic            mdBusy, mdErr;
   logic [CntW-1:0] stallCycles, flushCount;

   int checks = 0;
   int errors = 0;

   // Model state: cycles of busy remaining after the current one, sticky error, counters.
   int rem       = 0;
   bit m_err     = 0;
   int m_stalls  = 0;
   int m_flushes = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MD_LATENCY(Lat), .CNT_W(CntW)) dut (
      .clk(clk), .reset(reset),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .JumpD(JumpD), .JumpRegD(JumpRegD), .PCSrcD(PCSrcD),
      .mdUseD(mdUseD), .mdStartE(mdStartE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mdBusy(mdBusy), .mdErr(mdErr),
      .stallCycles(stallCycles), .flushCount(flushCount)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // True when destination w is a real register read as a or (optionally) b.
   function automatic bit dep(input logic [4:0] w, input logic [4:0] a, input logic [4:0] b,
                              input bit use_b);
      if (w == 0) return 0;
      return (w == a) || (use_b && (w == b));
   endfunction

   function automatic bit m_busy();
      return (mdStartE == 1'b1) || (rem > 0);
   endfunction

   function automatic bit m_stall();
      bit lw, br, md, use_rt;
      use_rt = !JumpRegD;
      lw = MemtoRegE && dep(RtE, RsD, RtD, 1'b1);
      br = (BranchD || JumpRegD) &&
           ((RegWriteE && dep(WriteRegE, RsD, RtD, use_rt)) ||
            (MemtoRegM && dep(WriteRegM, RsD, RtD, use_rt)));
      md = mdUseD && m_busy();
      return lw || br || md;
   endfunction

   function automatic bit m_flushd();
      return (PCSrcD || JumpD || JumpRegD) && !m_stall();
   endfunction

   function automatic int m_fwd(input logic [4:0] src);
      if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2;
      if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 1;
      return 0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rem = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (m_stall() && m_stalls < SatMax) m_stalls++;
         if (m_flushd() && m_flushes < SatMax) m_flushes++;
         if (rem > 0) begin
            if (mdStartE) m_err = 1;
            rem--;
         end else if (mdStartE) begin
            rem = Lat;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         check("StallF", int'(StallF), 0);
         check("StallD", int'(StallD), 0);
         check("FlushD", int'(FlushD), 1);
         check("FlushE", int'(FlushE), 1);
         check("FwdAD", int'(ForwardAD), 0);
         check("FwdBD", int'(ForwardBD), 0);
         check("FwdAE", int'(ForwardAE), 0);
         check("FwdBE", int'(ForwardBE), 0);
         check("mdBusy", int'(mdBusy), 0);
      end else begin
         check("StallF", int'(StallF), int'(m_stall()));
         check("StallD", int'(StallD), int'(m_stall()));
         check("FlushE", int'(FlushE), int'(m_stall()));
         check("FlushD", int'(FlushD), int'(m_flushd()));
         check("FwdAD", int'(ForwardAD), (RegWriteM && dep(WriteRegM, RsD, RsD, 0)) ? 1 : 0);
         check("FwdBD", int'(ForwardBD), (RegWriteM && dep(WriteRegM, RtD, RtD, 0)) ? 1 : 0);
         check("FwdAE", int'(ForwardAE), m_fwd(RsE));
         check("FwdBE", int'(ForwardBE), m_fwd(RtE));
         check("mdBusy", int'(mdBusy), int'(m_busy()));
      end
      check("mdErr", int'(mdErr), int'(m_err));
      check("stallCycles", int'(stallCycles), m_stalls);
      check("flushCount", int'(flushCount), m_flushes);
   end

   task automatic clr_in();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; JumpD = 0; JumpRegD = 0; PCSrcD = 0; mdUseD = 0; mdStartE = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mdBusy expected in cycles 0..6 after a start in cycle 0 (bit k = cycle k).
   logic [6:0] busy_pat = 7'b0011111;

   initial begin
      clr_in();
      #1 reset = 1'b1;
      #1;
      check("rst_StallF", int'(StallF), 0);
      check("rst_FlushD", int'(FlushD), 1);
      check("rst_FlushE", int'(FlushE), 1);
      check("rst_mdBusy", int'(mdBusy), 0);
      check("rst_stallCycles", int'(stallCycles), 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // Load-use stall
      tick(); clr_in(); MemtoRegE = 1; RtE = 5; RsD = 5;
      #5;
      check("lu_StallF", int'(StallF), 1);
      check("lu_StallD", int'(StallD), 1);
      check("lu_FlushE", int'(FlushE), 1);
      check("lu_FlushD", int'(FlushD), 0);
      tick(); clr_in();
      #5;
      check("lu_clear", int'(StallF), 0);
      check("lu_stallCycles", int'(stallCycles), 1);

      // Branch stall then resolve
      tick(); clr_in(); BranchD = 1; RsD = 8; RegWriteE = 1; WriteRegE = 8; PCSrcD = 1;
      #5;
      check("br_StallD", int'(StallD), 1);
      check("br_FlushD", int'(FlushD), 0);
      tick(); WriteRegE = 0;
      #5;
      check("br_FlushD2", int'(FlushD), 1);
      tick(); clr_in();
      #5;
      check("br_flushCount", int'(flushCount), 1);
      check("br_stallCycles", int'(stallCycles), 2);

      // Forward priority
      tick(); clr_in(); RsE = 3; RegWriteM = 1; RegWriteW = 1; WriteRegM = 3; WriteRegW = 3;
      #5;
      check("fwd_M", int'(ForwardAE), 2);
      RegWriteM = 0; #1;
      check("fwd_W", int'(ForwardAE), 1);
      RsE = 0; #1;
      check("fwd_zero", int'(ForwardAE), 0);
      tick(); clr_in(); RtE = 7; RsD = 7; RtD = 7; RegWriteM = 1; WriteRegM = 7;
      #5;
      check("fwd_BE", int'(ForwardBE), 2);
      check("fwd_AD", int'(ForwardAD), 1);
      check("fwd_BD", int'(ForwardBD), 1);

      // MD sequencing with a dependent consumer
      tick(); clr_in(); mdStartE = 1; mdUseD = 1;
      #5;
      check("md_busy0", int'(mdBusy), 1);
      for (int k = 1; k <= 6; k++) begin
         tick(); mdStartE = 0; mdUseD = 1;
         #5;
         check("md_busy", int'(mdBusy), int'(busy_pat[k]));
         check("md_stall", int'(StallD), int'(busy_pat[k]));
      end
      check("md_stallCycles", int'(stallCycles), 7);
      check("md_err_clean", int'(mdErr), 0);

      // MD protocol error: second start at cycle 2
      tick(); clr_in(); mdStartE = 1;
      #5;
      check("mderr_busy0", int'(mdBusy), 1);
      for (int k = 1; k <= 6; k++) begin
         tick(); mdStartE = (k == 2);
         #5;
         check("mderr_busy", int'(mdBusy), int'(busy_pat[k]));
      end
      check("mderr_set", int'(mdErr), 1);
      tick(); clr_in();
      #5;
      check("mderr_sticky", int'(mdErr), 1);

      // Asynchronous reset mid-BUSY
      tick(); clr_in(); mdStartE = 1;
      tick(); mdStartE = 0;
      tick();
      #2 reset = 1'b1;
      #1;
      check("ar_mdBusy", int'(mdBusy), 0);
      check("ar_FlushD", int'(FlushD), 1);
      check("ar_FlushE", int'(FlushE), 1);
      check("ar_stallCycles", int'(stallCycles), 0);
      check("ar_flushCount", int'(flushCount), 0);
      check("ar_mdErr", int'(mdErr), 0);
      tick(); reset = 1'b0; clr_in();
      #5;
      check("ar_idle", int'(mdBusy), 0);
      tick(); mdStartE = 1;
      #5;
      check("ar_busy0", int'(mdBusy), 1);
      for (int k = 1; k <= 6; k++) begin
         tick(); mdStartE = 0;
         #5;
         check("ar_busy", int'(mdBusy), int'(busy_pat[k]));
      end
      check("ar_noerr", int'(mdErr), 0);

      // jr compares only rs; MemtoRegM dependency; register $0
      tick(); clr_in(); JumpRegD = 1; RsD = 2; RtD = 8; RegWriteE = 1; WriteRegE = 8;
      #5;
      check("jr_rt_nostall", int'(StallD), 0);
      check("jr_flush", int'(FlushD), 1);
      RsD = 8; #1;
      check("jr_rs_stall", int'(StallD), 1);
      check("jr_noflush", int'(FlushD), 0);
      tick(); clr_in(); BranchD = 1; RtD = 9; MemtoRegM = 1; WriteRegM = 9;
      #5;
      check("br_memM", int'(StallD), 1);
      tick(); clr_in(); MemtoRegE = 1; RtE = 0; RsD = 0;
      #5;
      check("zero_nostall", int'(StallD), 0);

      // Saturation of both counters
      for (int k = 0; k < 20; k++) begin
         tick(); clr_in(); MemtoRegE = 1; RtE = 4; RtD = 4;
      end
      for (int k = 0; k < 20; k++) begin
         tick(); clr_in(); JumpD = 1;
      end
      tick(); clr_in();
      #5;
      check("sat_stall", int'(stallCycles), 15);
      check("sat_flush", int'(flushCount), 15);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
